// File: rtl/fht_input_loader.sv
// Input stage for fht_control: loads one frame of 4*2^A_BIT samples into four
// RAM banks in bit-reversed order, kicks the transform and waits for it to finish.
module fht_input_loader #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iVALID,
   input  logic [D_BIT-1:0] iDATA,
   output logic             oREADY,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA_WR,
   output logic [3:0]       oWE,
   output logic             oSTART,
   input  logic             iFHT_RDY,
   output logic             oBUSY,
   output logic [7:0]       oFRAMES
);

   localparam int N_BIT = A_BIT + 2;

   typedef enum logic [1:0] {
      LOAD,
      KICK,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t           state;
   logic [N_BIT-1:0] n;
   logic [N_BIT-1:0] r;
   logic             accept;
   logic             last;

   always_comb begin
      r = '0;
      for (int unsigned i = 0; i < N_BIT; i++) begin
         r[i] = n[N_BIT-1-i];
      end
   end

   // Ready is a pure state decode so it falls the cycle after the last sample.
   assign oREADY = (state == LOAD);
   assign accept = iVALID & oREADY;
   assign last   = (n == '1);

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state    <= LOAD;
         n        <= '0;
         oWE      <= '0;
         oADDR_WR <= '0;
         oDATA_WR <= '0;
         oSTART   <= 1'b0;
         oBUSY    <= 1'b0;
         oFRAMES  <= '0;
      end else begin
         oWE    <= '0;
         oSTART <= 1'b0;
         case (state)
            LOAD: begin
               if (accept) begin
                  oWE      <= 4'b0001 << r[1:0];
                  oADDR_WR <= r[N_BIT-1:2];
                  oDATA_WR <= iDATA;
                  n        <= n + 1'b1;
                  // Start rises together with the final write so the FHT samples it after the write lands.
                  if (last) begin
                     state  <= KICK;
                     oSTART <= 1'b1;
                     oBUSY  <= 1'b1;
                  end
               end
            end
            KICK: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!iFHT_RDY) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (iFHT_RDY) begin
                  state   <= LOAD;
                  oBUSY   <= 1'b0;
                  oFRAMES <= oFRAMES + 8'd1;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: doc/fht_input_loader.md
# fht_input_loader

Input stage in front of `fht_control`. It accepts a stream of time-domain samples and writes one frame of 4·2^A_BIT samples into the four FHT RAM banks in bit-reversed order. When the frame is complete it pulses the start input of `fht_control`. It then holds off new samples until the conversion reports ready again.

## Interface
- `A_BIT`, default 8: bank address width. Bank size is 2^A_BIT; frame length N = 4·2^A_BIT; index width N_BIT = A_BIT+2.
- `D_BIT`, default 16: sample width.

Ports:
- `iCLK`  in  1  single clock; all logic on rising edge.
- `iRESET`  in  1  asynchronous, active-high reset.
- `iVALID`  in  1  sample present on `iDATA`.
- `iDATA`  in  D_BIT  input sample.
- `oREADY`  out  1  loader accepts a sample this cycle.
- `oADDR_WR`  out  A_BIT  bank address shared by all banks.
- `oDATA_WR`  out  D_BIT  write data shared by all banks.
- `oWE`  out  4  one-hot bank write enable; bit b selects bank b.
- `oSTART`  out  1  one-cycle start pulse to `fht_control` `iSTART`.
- `iFHT_RDY`  in  1  `oRDY` of `fht_control`; low while a conversion runs.
- `oBUSY`  out  1  high from `oSTART` until the conversion completes.
- `oFRAMES`  out  8  count of frames handed to the FHT; wraps at 255 to 0.

## Operation
- Sample index counter `n`, N_BIT wide. The counter increments on every accepted sample, i.e. when `iVALID & oREADY`.
- Bit reversal: r = bitreverse(n) over N_BIT bits.
  - Bank = r[1:0].
  - Bank address = r[N_BIT-1:2].
- State machine:
  - **LOAD** (reset state): `oREADY`=1.
    - Each accepted sample registers a write.
    - When the sample with n=N-1 is accepted, `n` wraps to 0 and the next state is KICK.
  - **KICK**: `oREADY`=0, `oSTART`=1 for exactly one cycle. Always moves to WAIT_BUSY.
  - **WAIT_BUSY**: `oREADY`=0. Waits for `iFHT_RDY`=0, then moves to WAIT_DONE.
  - **WAIT_DONE**: `oREADY`=0. When `iFHT_RDY`=1, increments `oFRAMES` and returns to LOAD.
- `oBUSY` = 1 in KICK, WAIT_BUSY and WAIT_DONE.
- While `oREADY`=0, `iVALID` is ignored: no write and no counter change.
- `iVALID` gaps during LOAD are allowed. A cycle with no accepted sample produces `oWE`=0 and leaves `n` unchanged.

## Timing
- Reset values, asynchronous on `iRESET`=1:
  - State = LOAD; `n`=0.
  - `oREADY`=1 as soon as reset deasserts.
  - `oWE`=0, `oADDR_WR`=0, `oDATA_WR`=0.
  - `oSTART`=0, `oBUSY`=0, `oFRAMES`=0.
- Write latency: a sample accepted at edge k appears on `oWE`/`oADDR_WR`/`oDATA_WR` for the cycle after edge k (one register stage). At most one `oWE` bit is high in any cycle.
- Last write and start: the write of sample N-1 is on the bus in the same cycle as KICK, so `oSTART` rises together with the final `oWE`. `fht_control` samples `iSTART` one edge later, after the last bank write has completed.
- Between `oSTART` and the return to LOAD, `oWE`=0.
- `oREADY` drops combinationally in the cycle after the last sample is accepted.
- WAIT_BUSY → WAIT_DONE takes at least one cycle. A `iFHT_RDY` that is 1 in the cycle right after `oSTART` does not end the conversion.
- `oREADY` is high again one cycle after `iFHT_RDY` is seen high in WAIT_DONE.
- Reset asserted mid-frame discards the partial frame: `n`=0 and no `oSTART` is issued.
- Reset in WAIT_* returns the block to LOAD; `oFRAMES` does not increment.

## Test plan
- Reset and idle, with A_BIT=2 (N=16): assert `iRESET` for 2 cycles → all outputs at their reset values; `oREADY`=1 after release.
- Bit-reversed mapping, A_BIT=2:
  - Feed samples 0..15 with `iDATA`=n.
  - Sample 1 → bank 0, addr 2. Sample 3 → bank 0, addr 3. Sample 5 → bank 2, addr 2. Sample 15 → bank 3, addr 3.
  - Every bank/address pair is written exactly once.
- Start handshake:
  - After sample 15, `oSTART` is high for exactly 1 cycle, coincident with the last `oWE`.
  - Hold `iFHT_RDY` low for 50 cycles, then raise it → `oREADY` returns 1 cycle later and `oFRAMES`=1.
- Backpressure: drive `iVALID`=1 continuously during WAIT_BUSY/WAIT_DONE → `oWE` stays 0 and the next frame begins at n=0.
- Gapped input: `iVALID` toggled 1,0,1,0 → writes occur only for accepted samples and the addresses match the contiguous-input case.
- Reset mid-frame: reset after 7 samples, then feed 16 samples → exactly one `oSTART`, after the 16th, and all writes follow the mapping from n=0.
